// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with unsigned/signed saturation and a global-stall valid/ready pipe.
// Optional sticky overflow flag (ports sticky_ovf, clr_sticky) when KS_STICKY_OVF_EN is defined.
module ks_pipe_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef KS_STICKY_OVF_EN
    input  logic             clr_sticky,
    output logic             sticky_ovf,
`endif
    output logic             ovf
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned BASE   = LEVELS / STAGES;
    localparam int unsigned REM    = LEVELS % STAGES;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_USAT = 2'd2,
        MODE_SSAT = 2'd3
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    typedef struct packed {
        logic             vld;
        mode_e            mode;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
        logic [WIDTH-1:0] p0;
        gp_t              gp;
    } beat_t;

    // A register rank sits in front of prefix level pos when pos is the first level of ranks 1..STAGES-1.
    function automatic logic is_boundary(input int unsigned pos);
        logic hit;
        hit = 1'b0;
        for (int unsigned r = 1; r < STAGES; r++) begin
            if (r * BASE + ((r < REM) ? r : REM) == pos) hit = 1'b1;
        end
        return hit;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic             w_c0;
    mode_e            w_mode;
    beat_t            w_li [LEVELS+1];
    beat_t            w_lo [LEVELS];
    beat_t            w_fin;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sum;
    logic             w_sov;
    logic             w_ovf;
    logic             w_unused;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_adv    = out_ready || !r_out_valid;
    assign in_ready = w_adv;

    always_comb begin
        w_mode  = mode_e'(mode);
        w_bp    = (w_mode == MODE_SUB) ? ~b : b;
        w_c0    = (w_mode == MODE_SUB) ? 1'b1 : cin;
        w_p0    = a ^ w_bp;
        w_g0    = a & w_bp;
        // carry-in enters as the generate of bit -1, merged into bit 0
        w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
        w_li[0].vld   = in_valid;
        w_li[0].mode  = w_mode;
        w_li[0].c0    = w_c0;
        w_li[0].a_msb = a[WIDTH-1];
        w_li[0].b_msb = w_bp[WIDTH-1];
        w_li[0].p0    = w_p0;
        w_li[0].gp.g  = w_g0;
        w_li[0].gp.p  = w_p0;
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned D = 32'd1 << l;
        logic [WIDTH-1:0] w_g;
        logic [WIDTH-1:0] w_p;
        beat_t            w_o;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_op
                assign w_g[i] = w_li[l].gp.g[i] | (w_li[l].gp.p[i] & w_li[l].gp.g[i-D]);
                assign w_p[i] = w_li[l].gp.p[i] & w_li[l].gp.p[i-D];
            end else begin : g_pass
                assign w_g[i] = w_li[l].gp.g[i];
                assign w_p[i] = w_li[l].gp.p[i];
            end
        end
        always_comb begin
            w_o      = w_li[l];
            w_o.gp.g = w_g;
            w_o.gp.p = w_p;
        end
        assign w_lo[l] = w_o;
    end

    for (genvar q = 1; q <= LEVELS; q++) begin : g_pos
        if (is_boundary(q)) begin : g_reg
            beat_t r_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_adv) begin
                    r_q <= w_lo[q-1];
                end
            end
            assign w_li[q] = r_q;
        end else begin : g_wire
            assign w_li[q] = w_lo[q-1];
        end
    end

    assign w_fin    = w_li[LEVELS];
    assign w_unused = &{1'b0, w_fin.gp.p};

    always_comb begin
        w_carry = w_fin.gp.g;
        w_raw   = w_fin.p0 ^ {w_carry[WIDTH-2:0], w_fin.c0};
        w_sov   = (w_fin.a_msb == w_fin.b_msb) && (w_raw[WIDTH-1] != w_fin.a_msb);
        w_sum   = w_raw;
        w_ovf   = w_sov;
        case (w_fin.mode)
            MODE_USAT: begin
                w_sum = w_carry[WIDTH-1] ? '1 : w_raw;
                w_ovf = w_carry[WIDTH-1];
            end
            MODE_SSAT: begin
                if (w_sov) w_sum = w_fin.a_msb ? SMIN : SMAX;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_fin.vld;
            r_sum       <= w_sum;
            r_cout      <= w_carry[WIDTH-1];
            r_ovf       <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

`ifdef KS_STICKY_OVF_EN
    logic r_sticky;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_out_valid && out_ready && r_ovf) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end
    assign sticky_ovf = r_sticky;
`endif

endmodule

// File: tb/tb_ks_pipe_adder.sv
// Directed self-checking bench for ks_pipe_adder (WIDTH=8, STAGES=2); covers sticky flag when KS_STICKY_OVF_EN is defined.
module tb_ks_pipe_adder;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef KS_STICKY_OVF_EN
    logic             clr_sticky;
    logic             sticky_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ks_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef KS_STICKY_OVF_EN
        .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf),
`endif
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vcin, input logic [1:0] vmode,
                           input logic [7:0] esum, input logic ecout, input logic eovf);
        int n;
        a = va; b = vb; cin = vcin; mode = vmode;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, n, STAGES);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    endtask

    task automatic drain;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = 2'd0;
`ifdef KS_STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        tick; tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // directed vectors
        run_one("add_ovf",   8'h7F, 8'h01, 1'b0, 2'd0, 8'h80, 1'b0, 1'b1);
        run_one("add_cin",   8'h10, 8'h20, 1'b1, 2'd0, 8'h31, 1'b0, 1'b0);
        run_one("add_wrap",  8'hFF, 8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        run_one("sub_neg",   8'h05, 8'h07, 1'b0, 2'd1, 8'hFE, 1'b0, 1'b0);
        run_one("sub_pos",   8'h07, 8'h05, 1'b0, 2'd1, 8'h02, 1'b1, 1'b0);
        run_one("sub_sovf",  8'h80, 8'h01, 1'b0, 2'd1, 8'h7F, 1'b1, 1'b1);
        run_one("usat_hit",  8'hF0, 8'h20, 1'b0, 2'd2, 8'hFF, 1'b1, 1'b1);
        run_one("usat_miss", 8'h10, 8'h20, 1'b1, 2'd2, 8'h31, 1'b0, 1'b0);
        run_one("usat_edge", 8'hFE, 8'h00, 1'b1, 2'd2, 8'hFF, 1'b0, 1'b0);
        run_one("ssat_neg",  8'h80, 8'hFF, 1'b0, 2'd3, 8'h80, 1'b1, 1'b1);
        run_one("ssat_pos",  8'h70, 8'h20, 1'b0, 2'd3, 8'h7F, 1'b0, 1'b1);
        run_one("ssat_miss", 8'h10, 8'h20, 1'b0, 2'd3, 8'h30, 1'b0, 1'b0);
        drain;

        // back-to-back stream with downstream stall in cycles 3..5
        sent = 0; got = 0;
        cin = 1'b0; mode = 2'd0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 10);
            a = 8'(sent);
            b = 8'(2 * sent);
            #1;
            if (!out_ready) check("stream_stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                check("stream_sum", 32'(sum), 32'(8'(3 * got)));
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
            tick;
        end
        check("stream_got", got, 10);
        check("stream_sent", sent, 10);
        drain;

        // reset with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'h11; b = 8'h22; cin = 1'b0; mode = 2'd0;
        tick;
        a = 8'h01; b = 8'h02;
        tick;
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        check("inflight_sum", 32'(sum), 32'h33);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            tick;
        end
        check("midrst_no_ghost", seen, 0);
        run_one("post_rst", 8'h21, 8'h12, 1'b0, 2'd0, 8'h33, 1'b0, 1'b0);
        drain;

`ifdef KS_STICKY_OVF_EN
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        check("sticky_init_clr", 32'(sticky_ovf), 32'd0);
        run_one("stk_ovf", 8'h7F, 8'h01, 1'b0, 2'd0, 8'h80, 1'b0, 1'b1);
        tick;
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        run_one("stk_clean", 8'h01, 8'h01, 1'b0, 2'd0, 8'h02, 1'b0, 1'b0);
        tick;
        check("sticky_hold", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        check("sticky_clr", 32'(sticky_ovf), 32'd0);
        run_one("stk_ovf2", 8'h7F, 8'h01, 1'b0, 2'd0, 8'h80, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        drain;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
